// File: rtl/mem_stage_seq_if.sv
// Purpose: data-memory port bundle between the MEM-stage sequencer and data memory.
//   master : sequencer side (drives request, receives response)
//   slave  : memory side (receives request, drives response)
// Signals: d_mem_read, d_mem_write, d_mem_byte_enable[NB], d_mem_address[ADDR_W],
//          d_mem_wdata[DATA_W], d_mem_resp, d_mem_rdata[DATA_W]
interface mem_stage_seq_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned NB = DATA_W / 8;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [NB-1:0]     d_mem_byte_enable;
  logic [ADDR_W-1:0] d_mem_address;
  logic [DATA_W-1:0] d_mem_wdata;
  logic              d_mem_resp;
  logic [DATA_W-1:0] d_mem_rdata;

  modport master (
    output d_mem_read, d_mem_write, d_mem_byte_enable, d_mem_address, d_mem_wdata,
    input  d_mem_resp, d_mem_rdata
  );

  modport slave (
    input  d_mem_read, d_mem_write, d_mem_byte_enable, d_mem_address, d_mem_wdata,
    output d_mem_resp, d_mem_rdata
  );
endinterface

// File: rtl/mem_stage_seq.sv
// Purpose: LC-3b MEM-stage sequencer. Runs direct (LDR/STR/LDB/STB/TRAP) and two-phase
//   indirect (LDI/STI) data-memory accesses, waits on d_mem_resp with a timeout, stalls the
//   upstream pipeline while busy and aligns byte lanes.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   valid_in, opcode_in,          MEM control word of the instruction held in EX/MEM
//   mem_read_in, mem_write_in,
//   byte_op_in, addr_in, wdata_in
//   dmem (mem_stage_seq_if.master) registered request / memory response
//   mdr_out                       load result to MEM/WB (valid in the done cycle, then held)
//   stall, done                   pipeline hold / instruction-leaves-MEM pulse (same-cycle)
//   timeout                       sticky request timeout flag
//   stall_cycles                  stall-cycle perf counter
// Optional feature: define MEM_SEQ_PERF_EN to build the saturating stall_cycles counter;
//   otherwise stall_cycles is tied to 0. DATA_W must be a multiple of 8 and at least 16.
module mem_stage_seq #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [3:0]        opcode_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              byte_op_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  mem_stage_seq_if.master   dmem,
  output logic [DATA_W-1:0] mdr_out,
  output logic              stall,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  stall_cycles
);
  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned LW  = $clog2(NB);
  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

  localparam logic [3:0]        OP_LDI    = 4'b1010;
  localparam logic [3:0]        OP_STI    = 4'b1011;
  localparam logic [NB-1:0]     ALL_LANES = '1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(NB - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, IND_PTR, IND_FIN} state_t;

  state_t            state_q, state_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              byte_q, byte_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              store_q, store_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] mdr_q;

  logic              mem_op;
  logic              ind;
  logic [LW-1:0]     lane_in;
  logic              timed_out;
  logic [7:0]        load_byte;
  logic [DATA_W-1:0] load_val;

  assign mem_op    = valid_in & (mem_read_in | mem_write_in);
  assign ind       = (opcode_in == OP_LDI) | (opcode_in == OP_STI);
  assign lane_in   = addr_in[LW-1:0];
  assign timed_out = (wait_q == WCW'(MAX_WAIT));

  // Byte loads return the addressed lane zero-extended
  assign load_byte = 8'(dmem.d_mem_rdata >> {lane_q, 3'b000});
  assign load_val  = byte_q ? DATA_W'(load_byte) : dmem.d_mem_rdata;

  // Next-state, next-request and same-cycle pipeline outputs
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    byte_d    = byte_q;
    lane_d    = lane_q;
    store_d   = store_q;
    timeout_d = timeout_q;
    mdr_out   = mdr_q;
    stall     = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in && !mem_op) begin
          done = 1'b1;
        end else if (mem_op) begin
          stall   = 1'b1;
          wait_d  = '0;
          byte_d  = byte_op_in & ~ind;
          lane_d  = lane_in;
          store_d = ind ? (opcode_in == OP_STI) : mem_write_in;
          wdata_d = (byte_op_in && !ind) ? {NB{wdata_in[7:0]}} : wdata_in;
          if (ind) begin
            // Pointer fetch is always a full-word read
            state_d = IND_PTR;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
            be_d    = ALL_LANES;
            addr_d  = addr_in & WORD_MASK;
          end else begin
            state_d = ACCESS;
            rd_d    = mem_read_in & ~mem_write_in;
            wr_d    = mem_write_in;
            be_d    = byte_op_in ? (NB'(1) << lane_in) : ALL_LANES;
            addr_d  = byte_op_in ? addr_in : (addr_in & WORD_MASK);
          end
        end
      end

      default: begin
        if (timed_out) begin
          // Request was already dropped at the edge the counter reached MAX_WAIT
          done    = 1'b1;
          mdr_out = '0;
          state_d = IDLE;
          wait_d  = '0;
        end else if (dmem.d_mem_resp) begin
          wait_d = '0;
          if (state_q == IND_PTR) begin
            stall   = 1'b1;
            state_d = IND_FIN;
            rd_d    = ~store_q;
            wr_d    = store_q;
            be_d    = ALL_LANES;
            addr_d  = ADDR_W'(dmem.d_mem_rdata) & WORD_MASK;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            if (rd_q) mdr_out = load_val;
          end
        end else begin
          stall  = 1'b1;
          wait_d = wait_q + WCW'(1);
          if (wait_d == WCW'(MAX_WAIT)) begin
            rd_d      = 1'b0;
            wr_d      = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State and registered request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byte_q    <= 1'b0;
      lane_q    <= '0;
      store_q   <= 1'b0;
      timeout_q <= 1'b0;
      mdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      byte_q    <= byte_d;
      lane_q    <= lane_d;
      store_q   <= store_d;
      timeout_q <= timeout_d;
      mdr_q     <= mdr_out;
    end
  end

  assign dmem.d_mem_read        = rd_q;
  assign dmem.d_mem_write       = wr_q;
  assign dmem.d_mem_byte_enable = be_q;
  assign dmem.d_mem_address     = addr_q;
  assign dmem.d_mem_wdata       = wdata_q;
  assign timeout                = timeout_q;

`ifdef MEM_SEQ_PERF_EN
  logic [CNT_W-1:0] perf_q;

  // Saturating count of stall-high cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (stall && (perf_q != '1)) begin
      perf_q <= perf_q + CNT_W'(1);
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = '0;
`endif
endmodule
